// File: rtl/calc_ctrl_if.sv
// calc_ctrl_if: control/handshake bundle between the keypad front end,
// the register/ALU datapath and the calc_ctrl sequencer.
//   Front end -> controller : clear_i, digit_valid_i, op_valid_i, eq_i
//   ALU       -> controller : alu_done_i, alu_err_i
//   Controller -> datapath  : we_a_o, we_op_o, we_b_o, we_r_o, sel_a_o, alu_start_o
//   Controller status       : busy_o, err_o, state_o[2:0]
// Modports: master = environment side (front end + datapath), slave = controller.
interface calc_ctrl_if;
  logic       clear_i;
  logic       digit_valid_i;
  logic       op_valid_i;
  logic       eq_i;
  logic       alu_done_i;
  logic       alu_err_i;
  logic       we_a_o;
  logic       we_op_o;
  logic       we_b_o;
  logic       we_r_o;
  logic       sel_a_o;
  logic       alu_start_o;
  logic       busy_o;
  logic       err_o;
  logic [2:0] state_o;

  modport master (
    output clear_i, digit_valid_i, op_valid_i, eq_i, alu_done_i, alu_err_i,
    input  we_a_o, we_op_o, we_b_o, we_r_o, sel_a_o, alu_start_o,
    input  busy_o, err_o, state_o
  );

  modport slave (
    input  clear_i, digit_valid_i, op_valid_i, eq_i, alu_done_i, alu_err_i,
    output we_a_o, we_op_o, we_b_o, we_r_o, sel_a_o, alu_start_o,
    output busy_o, err_o, state_o
  );
endinterface

// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencing controller for the calculator datapath. Decodes
// keypad events into register write enables, starts the ALU and supervises
// its completion with a timeout. Carries no data.
// Ports:
//   clock_i  - system clock, rising edge
//   reset_i  - synchronous active-high reset
//   bus      - calc_ctrl_if.slave: user/ALU inputs, combinational enables
//              (we_*_o, sel_a_o, alu_start_o), registered busy_o/err_o/state_o
// Parameters: width (datapath width, informational), TIMEOUT (max WAIT cycles)
// Build option: CALC_CTRL_CHAIN_EN - an operator in DONE loads the result as
//   operand A and moves to OP_ENT (chained operation).
module calc_ctrl #(
  parameter int unsigned width   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic       clock_i,
  input logic       reset_i,
  calc_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  // Elaboration-time guard on the parameter ranges.
  if (TIMEOUT < 1 || width < 1) begin : g_param_check
    $error("calc_ctrl: TIMEOUT and width must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_ENT  = 3'd1,
    OP_ENT = 3'd2,
    B_ENT  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, err_q;
  logic              we_a, we_op, we_b, we_r, alu_start;
`ifdef CALC_CTRL_CHAIN_EN
  logic              sel_a;
`endif

  // State, timeout counter and registered status.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == WAIT);
      err_q   <= (state_d == ERR);
    end
  end

  // Next state and enable decode; within a state, the first accepted input
  // in clear > eq > op > digit order is the one acted on.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_a      = 1'b0;
    we_op     = 1'b0;
    we_b      = 1'b0;
    we_r      = 1'b0;
    alu_start = 1'b0;
`ifdef CALC_CTRL_CHAIN_EN
    sel_a     = 1'b0;
`endif
    // Enables are held low while reset or clear is being applied.
    if (reset_i || bus.clear_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.digit_valid_i) begin
            we_a    = 1'b1;
            state_d = A_ENT;
          end
        end
        A_ENT: begin
          if (bus.op_valid_i) begin
            we_op   = 1'b1;
            state_d = OP_ENT;
          end else if (bus.digit_valid_i) begin
            we_a = 1'b1;
          end
        end
        OP_ENT: begin
          if (bus.op_valid_i) begin
            we_op = 1'b1;
          end else if (bus.digit_valid_i) begin
            we_b    = 1'b1;
            state_d = B_ENT;
          end
        end
        B_ENT: begin
          if (bus.eq_i) begin
            alu_start = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
          end else if (bus.digit_valid_i) begin
            we_b = 1'b1;
          end
        end
        WAIT: begin
          // A done pulse in the final allowed cycle still beats the timeout.
          if (bus.alu_done_i) begin
            if (bus.alu_err_i) begin
              state_d = ERR;
            end else begin
              we_r    = 1'b1;
              state_d = DONE;
            end
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        DONE: begin
`ifdef CALC_CTRL_CHAIN_EN
          if (bus.op_valid_i) begin
            sel_a   = 1'b1;
            we_a    = 1'b1;
            we_op   = 1'b1;
            state_d = OP_ENT;
          end else if (bus.digit_valid_i) begin
            we_a    = 1'b1;
            state_d = A_ENT;
          end
`else
          if (bus.digit_valid_i) begin
            we_a    = 1'b1;
            state_d = A_ENT;
          end
`endif
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bus.we_a_o      = we_a;
  assign bus.we_op_o     = we_op;
  assign bus.we_b_o      = we_b;
  assign bus.we_r_o      = we_r;
  assign bus.alu_start_o = alu_start;
`ifdef CALC_CTRL_CHAIN_EN
  assign bus.sel_a_o     = sel_a;
`else
  assign bus.sel_a_o     = 1'b0;
`endif
  assign bus.busy_o      = busy_q;
  assign bus.err_o       = err_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed scoreboard bench for calc_ctrl. The stimulus
// process drives one input set per cycle and queues the expected outputs
// for that cycle; the monitor pops and compares on the falling edge.
module tb_calc_ctrl;

  localparam int unsigned Timeout = 16;
`ifdef CALC_CTRL_CHAIN_EN
  localparam bit Chain = 1'b1;
`else
  localparam bit Chain = 1'b0;
`endif

  // Input code: {reset, clear, eq, op, digit, alu_done, alu_err}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_AERR = 7'b0000001;
  localparam logic [6:0] I_DONE = 7'b0000010;
  localparam logic [6:0] I_DIG  = 7'b0000100;
  localparam logic [6:0] I_OP   = 7'b0001000;
  localparam logic [6:0] I_EQ   = 7'b0010000;
  localparam logic [6:0] I_CLR  = 7'b0100000;
  localparam logic [6:0] I_RST  = 7'b1000000;

  // Pulse code: {we_a, we_op, we_b, we_r, sel_a, alu_start}
  localparam logic [5:0] P_0   = 6'b000000;
  localparam logic [5:0] P_A   = 6'b100000;
  localparam logic [5:0] P_OP  = 6'b010000;
  localparam logic [5:0] P_B   = 6'b001000;
  localparam logic [5:0] P_R   = 6'b000100;
  localparam logic [5:0] P_SEL = 6'b000010;
  localparam logic [5:0] P_ST  = 6'b000001;

  typedef struct {
    string       name;
    logic [10:0] exp;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        mon_r;
  logic [10:0] mon_act;
  int          tests = 0;
  int          fails = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  calc_ctrl_if bus();

  calc_ctrl #(.width(8), .TIMEOUT(Timeout)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  task automatic drive(input logic [6:0] in);
    {rst, bus.clear_i, bus.eq_i, bus.op_valid_i, bus.digit_valid_i,
     bus.alu_done_i, bus.alu_err_i} = in;
  endtask

  // One cycle: apply inputs, queue expected pulses plus the state held this cycle.
  task automatic cyc(input string name, input logic [6:0] in,
                     input logic [5:0] pulse, input logic [2:0] st);
    rec_t r;
    drive(in);
    r.name = name;
    r.exp  = {pulse, (st == 3'd4), (st == 3'd6), st};
    exp_q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic to_wait(input string tag);
    cyc({tag, "_dig_a"}, I_DIG, P_A,  3'd0);
    cyc({tag, "_op"},    I_OP,  P_OP, 3'd1);
    cyc({tag, "_dig_b"}, I_DIG, P_B,  3'd2);
    cyc({tag, "_eq"},    I_EQ,  P_ST, 3'd3);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_r   = exp_q.pop_front();
      mon_act = {bus.we_a_o, bus.we_op_o, bus.we_b_o, bus.we_r_o, bus.sel_a_o,
                 bus.alu_start_o, bus.busy_o, bus.err_o, bus.state_o};
      tests++;
      if (mon_act !== mon_r.exp) begin
        fails++;
        $display("FAIL %s: got %b expected %b (we_a we_op we_b we_r sel_a start busy err state)",
                 mon_r.name, mon_act, mon_r.exp);
      end
    end
  end

  initial begin
    drive(I_NONE);
    @(posedge clk); #1;
    drive(I_RST);
    @(posedge clk); #1;

    // Basic sequence with done three cycles after eq.
    cyc("reset_state", I_NONE, P_0, 3'd0);
    to_wait("seq");
    cyc("wait1", I_NONE, P_0, 3'd4);
    cyc("wait2", I_NONE, P_0, 3'd4);
    cyc("done_ok", I_DONE, P_R, 3'd4);
    cyc("in_done", I_NONE, P_0, 3'd5);

    // Operator in DONE: chain or ignore.
    cyc("done_op", I_OP, Chain ? (P_A | P_OP | P_SEL) : P_0, 3'd5);
    cyc("done_op_clr", I_CLR, P_0, Chain ? 3'd2 : 3'd5);

    // Priority and in-state overwrite behaviour.
    cyc("clr_over_dig", I_CLR | I_DIG, P_0, 3'd0);
    cyc("idle_op_ign", I_OP | I_EQ, P_0, 3'd0);
    cyc("idle_dig", I_DIG, P_A, 3'd0);
    cyc("a_dig_again", I_DIG, P_A, 3'd1);
    cyc("a_op_over_dig", I_OP | I_DIG, P_OP, 3'd1);
    cyc("op_replace", I_OP, P_OP, 3'd2);
    cyc("op_dig", I_DIG, P_B, 3'd2);
    cyc("b_op_dig", I_OP | I_DIG, P_B, 3'd3);
    cyc("b_eq_op", I_EQ | I_OP, P_ST, 3'd3);
    cyc("wait_ign_user", I_DIG | I_OP | I_EQ, P_0, 3'd4);
    cyc("wait_clear", I_CLR, P_0, 3'd4);
    cyc("post_clr", I_NONE, P_0, 3'd0);
    cyc("stale_done", I_DONE, P_0, 3'd0);
    cyc("idle_after", I_NONE, P_0, 3'd0);

    // Timeout with no done.
    to_wait("tmo");
    for (int i = 0; i < int'(Timeout); i++) cyc("tmo_wait", I_NONE, P_0, 3'd4);
    cyc("tmo_err", I_NONE, P_0, 3'd6);
    cyc("err_dig", I_DIG, P_0, 3'd6);
    cyc("err_op", I_OP, P_0, 3'd6);
    cyc("err_eq_done", I_EQ | I_DONE, P_0, 3'd6);
    cyc("err_clear", I_CLR, P_0, 3'd6);

    // Done in the final allowed WAIT cycle wins.
    to_wait("last");
    for (int i = 0; i < int'(Timeout) - 1; i++) cyc("last_wait", I_NONE, P_0, 3'd4);
    cyc("last_done", I_DONE, P_R, 3'd4);
    cyc("last_in_done", I_NONE, P_0, 3'd5);
    cyc("done_dig", I_DIG, P_A, 3'd5);
    cyc("done_dig_st", I_CLR, P_0, 3'd1);

    // ALU error.
    to_wait("aerr");
    cyc("aerr_done", I_DONE | I_AERR, P_0, 3'd4);
    cyc("aerr_in_err", I_DIG, P_0, 3'd6);
    cyc("aerr_op", I_OP, P_0, 3'd6);
    cyc("aerr_clear", I_CLR, P_0, 3'd6);
    cyc("aerr_idle", I_NONE, P_0, 3'd0);

    // Reset in OP_ENT with a digit pending.
    cyc("r_dig", I_DIG, P_A, 3'd0);
    cyc("r_op", I_OP, P_OP, 3'd1);
    cyc("rst_opent", I_RST | I_DIG, P_0, 3'd2);
    cyc("after_rst", I_NONE, P_0, 3'd0);

    drive(I_NONE);
    @(posedge clk); #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the calculator datapath. It drives the write enables of the operand-A, operator, operand-B and result `dff_nbits` registers, and the operand-A input mux. It also starts the ALU and supervises its completion with a timeout. The block sits between the keypad/decoder front end and the register/ALU datapath, and carries no data itself.

## Interface
Parameters:
- `width`, 8, datapath width (carried for consistency, no internal data storage)
- `TIMEOUT`, 16, maximum WAIT cycles allowed for `alu_done_i` (≥1)

Ports:
- `clock_i`  in  1  single system clock, rising edge
- `reset_i`  in  1  synchronous, active-high reset
- `clear_i`  in  1  user clear, level sampled each cycle
- `digit_valid_i`  in  1  operand value on the register `d_i` bus is valid this cycle
- `op_valid_i`  in  1  operator code valid this cycle
- `eq_i`  in  1  equals request
- `alu_done_i`  in  1  ALU completion, one-cycle pulse
- `alu_err_i`  in  1  ALU error (e.g. divide by zero), qualified by `alu_done_i`
- `we_a_o`  out  1  write enable, operand-A register
- `we_op_o`  out  1  write enable, operator register
- `we_b_o`  out  1  write enable, operand-B register
- `we_r_o`  out  1  write enable, result register
- `sel_a_o`  out  1  operand-A mux select: 0 = keypad value, 1 = result register
- `alu_start_o`  out  1  ALU start pulse
- `busy_o`  out  1  ALU operation in progress
- `err_o`  out  1  error state
- `state_o`  out  3  current state encoding

## Operation
- State encodings: IDLE=0, A_ENT=1, OP_ENT=2, B_ENT=3, WAIT=4, DONE=5, ERR=6. Code 7 is unreachable and recovers to IDLE.
- Input priority each cycle: `clear_i` > `eq_i` > `op_valid_i` > `digit_valid_i`. Only the highest-priority input that the current state accepts is acted on; the others are dropped.
- `clear_i` in any state sends the next state to IDLE. No enable or start is asserted in that cycle.
- IDLE:
  - digit: `we_a_o`=1, `sel_a_o`=0, go to A_ENT.
  - op and eq: ignored.
- A_ENT:
  - digit: `we_a_o`=1, stay (overwrite).
  - op: `we_op_o`=1, go to OP_ENT.
  - eq: ignored.
- OP_ENT:
  - op: `we_op_o`=1, stay (operator replaced).
  - digit: `we_b_o`=1, go to B_ENT.
  - eq: ignored.
- B_ENT:
  - digit: `we_b_o`=1, stay.
  - eq: `alu_start_o`=1, go to WAIT.
  - op: ignored.
- WAIT:
  - `alu_done_i`=1 with `alu_err_i`=0: `we_r_o`=1, go to DONE.
  - `alu_done_i`=1 with `alu_err_i`=1: go to ERR; `we_r_o` stays 0.
  - All user inputs except clear are ignored.
- DONE:
  - digit: `we_a_o`=1, `sel_a_o`=0, go to A_ENT.
  - op: behaviour is set by configuration (see below).
  - eq: ignored.
- ERR: only `clear_i` (or reset) exits.
- Timeout counter:
  - Width is $clog2(TIMEOUT+1). It is cleared on every entry to WAIT and increments each WAIT cycle without `alu_done_i`.
  - In the TIMEOUT-th WAIT cycle with no done, the next state is ERR.
  - `alu_done_i` arriving in that same cycle wins over the timeout.
- An `alu_done_i` received outside WAIT (e.g. after clear aborted an operation) is ignored.

## Timing
- `we_*_o`, `sel_a_o` and `alu_start_o` are combinational decodes of the registered state and the current inputs. They are asserted in the same cycle as the triggering input, so the register captures the data at that cycle's edge. Each is a one-cycle pulse per accepted input.
- `busy_o`, `err_o` and `state_o` are registered:
  - `busy_o` is 1 exactly while in WAIT.
  - `err_o` is 1 exactly while in ERR.
- Input accepted in cycle N produces the new state visible on `state_o` in cycle N+1.
- Reset: the state is IDLE, the counter is 0, and every output is 0 in the cycle after `reset_i` is sampled high. Reset mid-WAIT abandons the operation.
- Minimum digit→op→digit→eq→result sequence: 4 input cycles plus ALU latency plus 1.

## Configuration
- `CALC_CTRL_CHAIN_EN` defined:
  - In DONE, `op_valid_i` asserts `sel_a_o`=1, `we_a_o`=1 and `we_op_o`=1 in the same cycle, then goes to OP_ENT.
  - The result therefore becomes operand A for a chained operation.
- Undefined:
  - In DONE, `op_valid_i` is ignored and `sel_a_o` is tied to 0.

## Test plan
- Reset, then digit, op, digit, eq in consecutive cycles, then `alu_done_i` 3 cycles later:
  - Enable pulses are `we_a`, `we_op`, `we_b`, `alu_start`, each in its input cycle.
  - `busy_o`=1 for 3 cycles, `we_r_o` pulses in the done cycle, and `state_o`=5.
- In B_ENT, drive `eq_i` and `op_valid_i` in the same cycle:
  - Only `alu_start_o` pulses and the next state is 4.
  - Then assert `clear_i` in WAIT with `alu_done_i` 2 cycles later: `state_o`=0 and no `we_r_o`.
- Reach WAIT and never assert done, with TIMEOUT=16:
  - `state_o` becomes 6 and `err_o`=1 after exactly 16 WAIT cycles.
  - Repeat with `alu_done_i` in the 16th WAIT cycle: the block goes to DONE and `we_r_o` pulses.
- In WAIT, drive `alu_done_i`=1 with `alu_err_i`=1:
  - ERR is entered and `we_r_o` stays 0.
  - Digits and ops are ignored while in ERR.
  - `clear_i` returns the block to IDLE.
- In DONE, drive `op_valid_i`:
  - With `CALC_CTRL_CHAIN_EN`: `sel_a_o`, `we_a_o` and `we_op_o` are all 1 in that cycle and the next state is 2.
  - Without it: no outputs change and the state stays 5.
- Assert `reset_i` for 1 cycle in OP_ENT while `digit_valid_i`=1: the next state is 0 and all outputs are 0.
